deco_scan: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with a built-in scan sequencer. In direct mode it latches a loaded address and drives the matching one-hot line. In scan mode it steps the active line through every position in turn, holding each for a programmable dwell, for example to drive digit or row selects. It generalises the team's combinational 3x8 decoder to any width and adds an enable, registered outputs, and an auto-scan mode.

---
 rtl/deco_scan.sv | 68 ++++++
 tb/tb_deco_scan.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/deco_scan.sv
// Registered N-to-2^N one-hot decoder with enable, address load and an
// auto-scan sequencer that holds each position for DWELL clocks.
module deco_scan #(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              load,
  input  logic [N-1:0]      a,
  output logic [(1<<N)-1:0] y,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int unsigned M  = 1 << N;
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;
  logic [N-1:0]  idx_nxt;

  function automatic logic [M-1:0] onehot(input logic [N-1:0] k);
    logic [M-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  always_comb begin
    idx_nxt = idx + N'(1);
  end

  // Priority: disable, then load (either mode), then direct, then scan step/count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      cnt  <= '0;
      y    <= '0;
      wrap <= 1'b0;
    end else if (!en) begin
      y    <= '0;
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      idx  <= a;
      y    <= onehot(a);
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (!mode) begin
      y    <= onehot(idx);
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      idx  <= idx_nxt;
      y    <= onehot(idx_nxt);
      wrap <= (idx == '1);
    end else begin
      cnt  <= cnt + CW'(1);
      y    <= onehot(idx);
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deco_scan.sv
// Directed bench for deco_scan: N=3/DWELL=4 instance for decode, scan, load,
// enable and reset behaviour; N=4/DWELL=1 instance for the single-cycle walk.
module tb_deco_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, mode, load;
  logic [2:0]  a;
  logic [7:0]  y;
  logic [2:0]  idx;
  logic        wrap;

  logic        b_en, b_mode, b_load;
  logic [3:0]  b_a;
  logic [15:0] b_y;
  logic [3:0]  b_idx;
  logic        b_wrap;

  int total = 0;
  int bad   = 0;

  deco_scan #(.N(3), .DWELL(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .a(a),
    .y(y), .idx(idx), .wrap(wrap)
  );

  deco_scan #(.N(4), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .load(b_load), .a(b_a),
    .y(b_y), .idx(b_idx), .wrap(b_wrap)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  exp_dir [8];
  logic [7:0]  ey;
  logic [15:0] eyb;

  initial begin
    exp_dir = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; a = '0;
    b_en = 1'b0; b_mode = 1'b0; b_load = 1'b0; b_a = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_y",    32'(y),    32'h0);
    check("rst_idx",  32'(idx),  32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_b_y",  32'(b_y),  32'h0);

    // direct decode of every address
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      load = 1'b1;
      a = 3'(k);
      step();
      check("dir_y",   32'(y),   32'(exp_dir[k]));
      check("dir_idx", 32'(idx), 32'(k));
    end

    // scan from idx 0: sample s=0 is the load cycle, a full sweep is 32 samples
    a = 3'd0;
    step();
    load = 1'b0;
    mode = 1'b1;
    for (int s = 0; s <= 54; s++) begin
      if (s > 0) step();
      ey = exp_dir[(s / 4) % 8];
      check("scan_y",    32'(y),    32'(ey));
      check("scan_wrap", 32'(wrap), (s > 0 && s % 32 == 0) ? 32'h1 : 32'h0);
    end
    check("scan_pos5_idx", 32'(idx), 32'd5);

    // load a=2 at dwell count 2 of index 5
    load = 1'b1;
    a = 3'd2;
    step();
    load = 1'b0;
    check("ld_y",    32'(y),    32'h04);
    check("ld_idx",  32'(idx),  32'd2);
    check("ld_wrap", 32'(wrap), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ld_dwell_y",    32'(y),    32'h04);
      check("ld_dwell_wrap", 32'(wrap), 32'h0);
    end
    step();
    check("ld_next_y", 32'(y), 32'h08);

    // advance to index 6, dwell count 2
    repeat (14) step();
    check("pre_gap_y",   32'(y),   32'h40);
    check("pre_gap_idx", 32'(idx), 32'd6);

    // enable gap with an ignored load
    en = 1'b0;
    load = 1'b1;
    a = 3'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("gap_y",    32'(y),    32'h0);
      check("gap_idx",  32'(idx),  32'd6);
      check("gap_wrap", 32'(wrap), 32'h0);
    end
    en = 1'b1;
    load = 1'b0;
    // the disabled cycles cleared cnt, so index 6 is re-dwelled from count 0
    for (int i = 0; i < 3; i++) begin
      step();
      check("reen_y",   32'(y),   32'h40);
      check("reen_idx", 32'(idx), 32'd6);
    end
    step();
    check("reen_next_y",   32'(y),   32'h80);
    check("reen_next_idx", 32'(idx), 32'd7);

    // asynchronous reset mid-cycle while scanning
    #3;
    rst = 1'b1;
    #1;
    check("arst_y",    32'(y),    32'h0);
    check("arst_idx",  32'(idx),  32'h0);
    check("arst_wrap", 32'(wrap), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("arst_hold_y",   32'(y),   32'h0);
      check("arst_hold_idx", 32'(idx), 32'h0);
    end
    rst = 1'b0;
    step();
    check("post_rst_y",   32'(y),   32'h01);
    check("post_rst_idx", 32'(idx), 32'h0);

    // N=4, DWELL=1 walk: load 0 then step every cycle
    b_en = 1'b1;
    b_mode = 1'b1;
    b_load = 1'b1;
    b_a = 4'd0;
    step();
    b_load = 1'b0;
    for (int s = 0; s <= 33; s++) begin
      if (s > 0) step();
      eyb = 16'h0001 << (s % 16);
      check("walk_y",    32'(b_y),    32'(eyb));
      check("walk_idx",  32'(b_idx),  32'(s % 16));
      check("walk_wrap", 32'(b_wrap), (s > 0 && s % 16 == 0) ? 32'h1 : 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
